// File: rtl/bfsk_tx_ctrl.sv
// bfsk_tx_ctrl: frame sequencer for the BFSK transmit path.
// Takes payload bytes on a valid/ready stream and emits a frame made of an
// alternating preamble, a sync byte and the payload (MSB first). Each bit holds
// the modulator phase increment (mark or space) for exactly SPB sample clocks.
// A fixed idle gap follows every frame, whether it ended normally or by underrun.
module bfsk_tx_ctrl #(
  parameter int unsigned SPB       = 200,
  parameter logic [31:0] PH_MARK   = 32'h0AAAAAAB,
  parameter logic [31:0] PH_SPACE  = 32'h05555555,
  parameter int unsigned PRE_BITS  = 16,
  parameter logic [7:0]  SYNC_WORD = 8'hD3,
  parameter int unsigned GAP_BITS  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [31:0] ph_inc,
  output logic        tx_en,
  output logic        bit_stb,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  // Counter widths. bit_cnt must reach both PRE_BITS-1 and 7.
  localparam int unsigned BMAX     = (PRE_BITS > 32'd8) ? PRE_BITS : 32'd8;
  localparam int unsigned SCW      = (SPB > 32'd1) ? $clog2(SPB) : 32'd1;
  localparam int unsigned BCW      = $clog2(BMAX);
  localparam int unsigned GAP_CLKS = GAP_BITS * SPB;
  localparam int unsigned GCW      = (GAP_CLKS > 32'd1) ? $clog2(GAP_CLKS) : 32'd1;

  localparam logic [SCW-1:0] SYM_LAST = SCW'(SPB - 32'd1);
  localparam logic [BCW-1:0] PRE_LAST = BCW'(PRE_BITS - 32'd1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(7);
  localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_CLKS - 32'd1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SYNC = 3'd2,
    ST_DATA = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  // Map a data bit onto the modulator phase increment.
  function automatic logic [31:0] sel_ph(input logic b);
    sel_ph = b ? PH_MARK : PH_SPACE;
  endfunction

  state_t         state_q, state_d;
  logic [SCW-1:0] sym_cnt_q, sym_cnt_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GCW-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]     sh_q, sh_d;
  logic [7:0]     hold_q, hold_d;
  logic           hold_v_q, hold_v_d;
  logic           hold_last_q, hold_last_d;
  logic           cur_last_q, cur_last_d;
  logic           last_seen_q, last_seen_d;
  logic [31:0]    ph_inc_q, ph_inc_d;
  logic           tx_en_q, tx_en_d;
  logic           bit_stb_q, bit_stb_d;
  logic           busy_q, busy_d;
  logic           frame_done_q, frame_done_d;
  logic           underrun_q, underrun_d;

  logic bit_end_s;
  logic accept_s;

  // Ready depends on registered state only so the source never sees a comb path.
  assign s_ready   = !hold_v_q && !last_seen_q && (state_q != ST_GAP);
  assign accept_s  = s_valid && s_ready;
  assign bit_end_s = (sym_cnt_q == SYM_LAST);

  assign ph_inc     = ph_inc_q;
  assign tx_en      = tx_en_q;
  assign bit_stb    = bit_stb_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

  // Next-state logic: sequencing, bit selection and holding-register handshake.
  always_comb begin
    state_d      = state_q;
    sym_cnt_d    = sym_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    sh_d         = sh_q;
    hold_d       = hold_q;
    hold_v_d     = hold_v_q;
    hold_last_d  = hold_last_q;
    cur_last_d   = cur_last_q;
    last_seen_d  = last_seen_q;
    ph_inc_d     = ph_inc_q;
    bit_stb_d    = 1'b0;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          // First preamble bit is always a mark.
          state_d   = ST_PRE;
          sym_cnt_d = '0;
          bit_cnt_d = '0;
          ph_inc_d  = PH_MARK;
          bit_stb_d = 1'b1;
        end else begin
          sym_cnt_d = '0;
          ph_inc_d  = 32'h0000_0000;
        end
      end

      ST_PRE: begin
        if (bit_end_s) begin
          sym_cnt_d = '0;
          bit_stb_d = 1'b1;
          if (bit_cnt_q == PRE_LAST) begin
            state_d   = ST_SYNC;
            bit_cnt_d = '0;
            sh_d      = SYNC_WORD;
            ph_inc_d  = sel_ph(SYNC_WORD[7]);
          end else begin
            // Bit k is ~k[0], so bit k+1 equals k[0].
            bit_cnt_d = bit_cnt_q + BCW'(1);
            ph_inc_d  = sel_ph(bit_cnt_q[0]);
          end
        end else begin
          sym_cnt_d = sym_cnt_q + SCW'(1);
        end
      end

      ST_SYNC: begin
        if (bit_end_s) begin
          sym_cnt_d = '0;
          bit_stb_d = 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            // Holding register was filled by the byte that started the frame.
            state_d    = ST_DATA;
            bit_cnt_d  = '0;
            sh_d       = hold_q;
            hold_v_d   = 1'b0;
            cur_last_d = hold_last_q;
            ph_inc_d   = sel_ph(hold_q[7]);
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
            sh_d      = {sh_q[6:0], 1'b0};
            ph_inc_d  = sel_ph(sh_q[6]);
          end
        end else begin
          sym_cnt_d = sym_cnt_q + SCW'(1);
        end
      end

      ST_DATA: begin
        if (bit_end_s) begin
          sym_cnt_d = '0;
          if (bit_cnt_q != BIT_LAST) begin
            bit_stb_d = 1'b1;
            bit_cnt_d = bit_cnt_q + BCW'(1);
            sh_d      = {sh_q[6:0], 1'b0};
            ph_inc_d  = sel_ph(sh_q[6]);
          end else if (cur_last_q) begin
            frame_done_d = 1'b1;
            state_d      = ST_GAP;
            bit_cnt_d    = '0;
            gap_cnt_d    = '0;
            ph_inc_d     = 32'h0000_0000;
          end else if (hold_v_q) begin
            bit_stb_d  = 1'b1;
            bit_cnt_d  = '0;
            sh_d       = hold_q;
            hold_v_d   = 1'b0;
            cur_last_d = hold_last_q;
            ph_inc_d   = sel_ph(hold_q[7]);
          end else begin
            // Next byte did not arrive in time: abort the frame.
            underrun_d = 1'b1;
            state_d    = ST_GAP;
            bit_cnt_d  = '0;
            gap_cnt_d  = '0;
            ph_inc_d   = 32'h0000_0000;
          end
        end else begin
          sym_cnt_d = sym_cnt_q + SCW'(1);
        end
      end

      ST_GAP: begin
        sym_cnt_d = '0;
        ph_inc_d  = 32'h0000_0000;
        if (gap_cnt_q == GAP_LAST) begin
          state_d     = ST_IDLE;
          gap_cnt_d   = '0;
          last_seen_d = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q + GCW'(1);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        sym_cnt_d = '0;
        bit_cnt_d = '0;
        gap_cnt_d = '0;
        ph_inc_d  = 32'h0000_0000;
      end
    endcase

    // Accept is only possible while hold is empty, so it never races a load.
    if (accept_s) begin
      hold_d      = s_data;
      hold_v_d    = 1'b1;
      hold_last_d = s_last;
      if (s_last) begin
        last_seen_d = 1'b1;
      end else begin
        last_seen_d = last_seen_d;
      end
    end else begin
      hold_d = hold_d;
    end

    tx_en_d = (state_d == ST_PRE) || (state_d == ST_SYNC) || (state_d == ST_DATA);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any frame in flight silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sym_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      sh_q         <= 8'h00;
      hold_q       <= 8'h00;
      hold_v_q     <= 1'b0;
      hold_last_q  <= 1'b0;
      cur_last_q   <= 1'b0;
      last_seen_q  <= 1'b0;
      ph_inc_q     <= 32'h0000_0000;
      tx_en_q      <= 1'b0;
      bit_stb_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sym_cnt_q    <= sym_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      sh_q         <= sh_d;
      hold_q       <= hold_d;
      hold_v_q     <= hold_v_d;
      hold_last_q  <= hold_last_d;
      cur_last_q   <= cur_last_d;
      last_seen_q  <= last_seen_d;
      ph_inc_q     <= ph_inc_d;
      tx_en_q      <= tx_en_d;
      bit_stb_q    <= bit_stb_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

endmodule

// File: tb/tb_bfsk_tx_ctrl.sv
// Bench for bfsk_tx_ctrl: scoreboard of expected per-bit phase increments and
// frame events, popped by a monitor whenever the DUT strobes a bit or an event.
module tb_bfsk_tx_ctrl;

  localparam logic [31:0] MARK  = 32'h0AAAAAAB;
  localparam logic [31:0] SPACE = 32'h05555555;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid, s_last, s_ready;
  logic [31:0] ph_inc;
  logic        tx_en, bit_stb, busy, frame_done, underrun;

  logic [7:0]  d_data;
  logic        d_valid, d_last, d_ready;
  logic [31:0] d_ph;
  logic        d_tx_en, d_stb, d_busy, d_done, d_underrun;

  bfsk_tx_ctrl #(.SPB(4), .PRE_BITS(4), .GAP_BITS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .ph_inc(ph_inc), .tx_en(tx_en), .bit_stb(bit_stb), .busy(busy),
    .frame_done(frame_done), .underrun(underrun));

  bfsk_tx_ctrl u_def (
    .clk(clk), .rst_n(rst_n), .s_data(d_data), .s_valid(d_valid), .s_last(d_last),
    .s_ready(d_ready), .ph_inc(d_ph), .tx_en(d_tx_en), .bit_stb(d_stb), .busy(d_busy),
    .frame_done(d_done), .underrun(d_underrun));

  typedef struct {
    int kind;  // 1 = frame_done, 2 = underrun
    int lat;   // clocks from accept of first byte
  } evt_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nbits = 0;
  int frame_t0 = 0;
  logic [31:0] prev_ph = 32'h0;
  logic [31:0] exp_ph_q[$];
  evt_t        evt_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_ph_q.push_back(b[i] ? MARK : SPACE);
  endtask

  // Preamble 1,0,1,0 then sync byte D3.
  task automatic push_head();
    exp_ph_q.push_back(MARK);
    exp_ph_q.push_back(SPACE);
    exp_ph_q.push_back(MARK);
    exp_ph_q.push_back(SPACE);
    push_byte(8'hD3);
  endtask

  task automatic push_evt(input int kind, input int lat);
    evt_t e;
    e.kind = kind;
    e.lat  = lat;
    evt_q.push_back(e);
  endtask

  // Monitor: compare each strobed bit and each event against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_ph_q.delete();
      evt_q.delete();
    end else begin
      if (bit_stb) begin
        nbits <= nbits + 1;
        if (exp_ph_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_bit: got ph %h expected no bit (cyc %0d)", ph_inc, cyc);
        end else begin
          check("bit_ph", ph_inc, exp_ph_q.pop_front());
          check("bit_txen", {31'h0, tx_en}, 32'h1);
        end
      end else if (tx_en) begin
        check("ph_stable", ph_inc, prev_ph);
      end
      if (frame_done || underrun) begin
        check("evt_excl", {31'h0, frame_done & underrun}, 32'h0);
        if (evt_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_evt: got done=%0d underrun=%0d expected none", frame_done, underrun);
        end else begin
          evt_t e;
          e = evt_q.pop_front();
          check("evt_kind", frame_done ? 32'd1 : 32'd2, e.kind);
          check("evt_lat", cyc - frame_t0, e.lat);
          check("evt_txen", {31'h0, tx_en}, 32'h0);
          check("evt_ph", ph_inc, 32'h0);
        end
      end
      prev_ph <= ph_inc;
    end
  end

  task automatic send(input logic [7:0] b, input logic last, output int acc);
    int k;
    @(negedge clk);
    s_data = b; s_last = last; s_valid = 1'b1;
    k = 0;
    while (!s_ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (!s_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: got no s_ready expected accept of %h", b);
      s_valid = 1'b0;
      acc = cyc;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic wait_idle(input int lim, input string nm);
    int k;
    k = 0;
    while ((exp_ph_q.size() != 0 || evt_q.size() != 0 || busy) && k < lim) begin
      @(negedge clk);
      k++;
    end
    check(nm, (k >= lim) ? 32'd1 : 32'd0, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, k, nb0, n;
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    d_valid = 1'b0; d_last = 1'b0; d_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ph", ph_inc, 32'h0);
    check("rst_flags", {26'h0, tx_en, bit_stb, busy, frame_done, underrun, 1'b0}, 32'h0);
    check("rst_ready", {31'h0, s_ready}, 32'h1);
    rst_n = 1'b1;

    // One-byte frame A5: 20 bits, done 80 clocks after accept.
    push_head(); push_byte(8'hA5); push_evt(1, 80);
    send(8'hA5, 1'b1, t);
    frame_t0 = t;
    k = 0;
    while (!frame_done && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", {31'h0, frame_done}, 32'h1);

    // Source offers a byte throughout the gap: ready must stay low 16 clocks.
    push_head(); push_byte(8'h3C); push_evt(1, 80);
    s_data = 8'h3C; s_last = 1'b1; s_valid = 1'b1;
    check("gap_ready", {31'h0, s_ready}, 32'h0);
    check("gap_busy", {30'h0, busy, tx_en}, 32'h2);
    k = 0;
    while (!s_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("gap_clks", k, 32'd16);
    @(posedge clk);
    #1;
    frame_t0 = cyc;
    s_valid = 1'b0; s_last = 1'b0;
    wait_idle(400, "idle_3c");

    // Back-to-back 01,FF,80: 36 contiguous bits, no underrun.
    push_head(); push_byte(8'h01); push_byte(8'hFF); push_byte(8'h80); push_evt(1, 144);
    nb0 = nbits;
    send(8'h01, 1'b0, t);
    frame_t0 = t;
    send(8'hFF, 1'b0, t);
    send(8'h80, 1'b1, t);
    wait_idle(600, "idle_b2b");
    check("b2b_bits", nbits - nb0, 32'd36);

    // Second byte never offered in time: underrun at end of byte 1.
    push_head(); push_byte(8'hC3); push_evt(2, 80);
    send(8'hC3, 1'b0, t);
    frame_t0 = t;
    wait_idle(400, "idle_underrun");
    push_head(); push_byte(8'h5E); push_evt(1, 80);
    send(8'h5E, 1'b1, t);
    frame_t0 = t;
    wait_idle(400, "idle_after_ur");

    // Reset in the middle of the payload of frame 5A.
    push_head(); push_byte(8'h5A);
    send(8'h5A, 1'b1, t);
    frame_t0 = t;
    repeat (58) @(negedge clk);
    check("pre_rst_busy", {31'h0, busy}, 32'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ph", ph_inc, 32'h0);
    check("mid_rst_flags", {27'h0, tx_en, bit_stb, busy, frame_done, underrun}, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_idle", {31'h0, busy}, 32'h0);
    push_head(); push_byte(8'h96); push_evt(1, 80);
    send(8'h96, 1'b1, t);
    frame_t0 = t;
    wait_idle(400, "idle_96");

    // Default parameters: one-byte frame keeps tx_en high 32*200 clocks.
    @(negedge clk);
    d_data = 8'h55; d_last = 1'b1; d_valid = 1'b1;
    check("def_ready", {31'h0, d_ready}, 32'h1);
    @(posedge clk);
    #1;
    d_valid = 1'b0; d_last = 1'b0;
    @(negedge clk);
    check("def_first_ph", d_ph, MARK);
    n = 0; nb0 = 0; k = 0;
    while (!d_done && k < 8000) begin
      if (d_tx_en) n++;
      if (d_stb) nb0++;
      check("def_no_underrun", {31'h0, d_underrun}, 32'h0);
      @(negedge clk);
      k++;
    end
    check("def_done", {31'h0, d_done}, 32'h1);
    check("def_txen_clks", n, 32'd6400);
    check("def_bits", nb0, 32'd32);
    check("def_busy_gap", {30'h0, d_busy, d_tx_en}, 32'h2);

    check("sb_empty", exp_ph_q.size() + evt_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
